// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pong match controller:
//   - state_t   : match state encoding (IDLE=0, SERVE=1, PLAY=2, PAUSED=3,
//                 GAME_OVER=4), also exported on o_State
//   - CMD_*     : UART command bytes ('S' start, 'P' pause, 'R' reset)
//   - cmd_hit() : qualifies a received byte against one command
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_RESET = 8'h52;

    // A byte is a command only on the cycle its strobe is high.
    function automatic logic cmd_hit(input logic       dv,
                                     input logic [7:0] rx_byte,
                                     input logic [7:0] cmd);
        return dv && (rx_byte == cmd);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl_if
// Bundles the signals around the match controller so a test environment or
// the surrounding Pong top can route them as one object.
//   rx_dv/rx_byte  : UART command strobe and byte
//   frame_tick     : one pulse per video frame
//   point          : per-player point pulses
//   state, game_active, ball_release, scores, winner_valid, winner_id :
//                    controller status
// Modports:
//   master : the side issuing commands/pulses (UART + game logic)
//   slave  : the controller side
//
// Strobe semantics: rx_dv, frame_tick and each point bit are single-cycle
// qualifiers. Data is sampled only on a cycle where its strobe is high and
// there is no back-pressure: the controller consumes every strobe on the
// cycle it arrives (ignored bytes are simply dropped).
// ---------------------------------------------------------------------------
interface pong_match_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_WIDTH = 4
);
    localparam int IDW = (NUM_PLAYERS > 2) ? 2 : 1;

    logic                               rx_dv;
    logic [7:0]                         rx_byte;
    logic                               frame_tick;
    logic [NUM_PLAYERS-1:0]             point;
    logic [2:0]                         state;
    logic                               game_active;
    logic                               ball_release;
    logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores;
    logic                               winner_valid;
    logic [IDW-1:0]                     winner_id;

    modport master (
        output rx_dv, rx_byte, frame_tick, point,
        input  state, game_active, ball_release, scores, winner_valid, winner_id
    );

    modport slave (
        input  rx_dv, rx_byte, frame_tick, point,
        output state, game_active, ball_release, scores, winner_valid, winner_id
    );
endinterface

// File: rtl/pong_frame_timer.sv
// ---------------------------------------------------------------------------
// pong_frame_timer
// Counts frame ticks up to TERMINAL with clear and freeze.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear to 0 (wins over counting)
//   run         : count enable; when low the count is frozen
//   frame_tick  : one-cycle frame pulse
//   done        : combinational pulse on the tick that reaches TERMINAL
// The counter wraps to 0 on that tick, so it is ready for reuse.
// done deliberately does not look at clear: the owner only clears the timer
// while it is not running, which keeps the owner's next-state logic free of
// a combinational loop through clear.
// ---------------------------------------------------------------------------
module pong_frame_timer #(
    parameter int TERMINAL = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic frame_tick,
    output logic done
);
    localparam int CW = (TERMINAL < 2) ? 1 : $clog2(TERMINAL);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == CW'(TERMINAL - 1));
    assign done    = run && frame_tick && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && frame_tick) begin
            count <= at_last ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
// Match controller for Pong: game state, per-player scores, serve delay and
// UART command handling for 2..4 players.
// Ports:
//   i_Clk, i_Rst_L   : clock, asynchronous active-low reset
//   i_RX_DV/i_RX_Byte: UART command strobe and byte ('S','P','R')
//   i_Frame_Tick     : one pulse per video frame
//   i_Point          : bit p pulses to credit player p
//   o_State          : current state (pong_pkg::state_t encoding)
//   o_Game_Active    : high in PLAY
//   o_Ball_Release   : one-cycle pulse when a serve delay completes
//   o_Scores         : player p at [p*SCORE_WIDTH +: SCORE_WIDTH]
//   o_Winner_Valid   : high in GAME_OVER
//   o_Winner_Id      : winning player, valid with o_Winner_Valid
// Strobes are single-cycle and always accepted; there is no back-pressure.
// Priority in one cycle: RESET > PAUSE/START > point.
// Optional build macro PONG_PAUSE_TIMEOUT_EN: PAUSED falls back to IDLE
// after IDLE_TIMEOUT_FRAMES frame ticks without a command.
// Parameter legality: NUM_PLAYERS 2..4, 1 <= WIN_SCORE < 2**SCORE_WIDTH,
// SERVE_DELAY_FRAMES >= 1.
// ---------------------------------------------------------------------------
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS         = 2,
    parameter int SCORE_WIDTH         = 4,
    parameter int WIN_SCORE           = 9,
    parameter int SERVE_DELAY_FRAMES  = 60,
    parameter int IDLE_TIMEOUT_FRAMES = 1800
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst_L,
    input  logic                               i_RX_DV,
    input  logic [7:0]                         i_RX_Byte,
    input  logic                               i_Frame_Tick,
    input  logic [NUM_PLAYERS-1:0]             i_Point,
    output logic [2:0]                         o_State,
    output logic                               o_Game_Active,
    output logic                               o_Ball_Release,
    output logic [NUM_PLAYERS*SCORE_WIDTH-1:0] o_Scores,
    output logic                               o_Winner_Valid,
    output logic [((NUM_PLAYERS > 2) ? 2 : 1)-1:0] o_Winner_Id
);
    localparam int IDW = (NUM_PLAYERS > 2) ? 2 : 1;

    state_t                  state, state_next;
    state_t                  ret_state, ret_next;   // where PAUSED returns to
    logic [SCORE_WIDTH-1:0]  scores [NUM_PLAYERS];
    logic [IDW-1:0]          winner_id;
    logic                    game_active, ball_release, winner_valid;

    logic                    is_start, is_pause, is_reset, any_cmd;
    logic                    point_any;
    logic [IDW-1:0]          point_idx;
    logic [SCORE_WIDTH-1:0]  new_score;
    logic                    do_clear, do_inc, latch_win;
    logic                    serve_clear, serve_run, serve_done;
    logic                    timeout_done;

    assign is_start  = cmd_hit(i_RX_DV, i_RX_Byte, CMD_START);
    assign is_pause  = cmd_hit(i_RX_DV, i_RX_Byte, CMD_PAUSE);
    assign is_reset  = cmd_hit(i_RX_DV, i_RX_Byte, CMD_RESET);
    assign any_cmd   = is_start || is_pause || is_reset;
    assign point_any = |i_Point;

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        point_idx = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (i_Point[p]) point_idx = IDW'(p);
        end
    end

    assign new_score = scores[point_idx] + SCORE_WIDTH'(1);

    // ---------------------------------------------------------------------
    // Serve delay. The counter is cleared on a fresh entry to SERVE but not
    // when returning from PAUSED, so a paused serve resumes where it froze.
    // A PAUSE or RESET in the same cycle as a tick stops that tick counting.
    // ---------------------------------------------------------------------
    assign serve_run   = (state == SERVE) && !is_pause && !is_reset;
    assign serve_clear = (state_next == SERVE) && (state != SERVE) &&
                         (state != PAUSED);

    pong_frame_timer #(
        .TERMINAL (SERVE_DELAY_FRAMES)
    ) u_serve_timer (
        .clk        (i_Clk),
        .rst_n      (i_Rst_L),
        .clear      (serve_clear),
        .run        (serve_run),
        .frame_tick (i_Frame_Tick),
        .done       (serve_done)
    );

`ifdef PONG_PAUSE_TIMEOUT_EN
    // Counts only while parked in PAUSED with no command this cycle; held
    // at zero in every other state so each pause starts a fresh count.
    pong_frame_timer #(
        .TERMINAL (IDLE_TIMEOUT_FRAMES)
    ) u_pause_timer (
        .clk        (i_Clk),
        .rst_n      (i_Rst_L),
        .clear      (state != PAUSED),
        .run        ((state == PAUSED) && !any_cmd),
        .frame_tick (i_Frame_Tick),
        .done       (timeout_done)
    );
`else
    localparam int unused_idle_timeout = IDLE_TIMEOUT_FRAMES;
    logic unused_any_cmd;
    assign unused_any_cmd = any_cmd;
    assign timeout_done   = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ret_next   = ret_state;
        do_clear   = 1'b0;
        do_inc     = 1'b0;
        latch_win  = 1'b0;
        if (is_reset) begin
            state_next = IDLE;
            do_clear   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (is_start) begin
                        state_next = SERVE;
                        do_clear   = 1'b1;
                    end
                end
                SERVE: begin
                    if (is_pause) begin
                        state_next = PAUSED;
                        ret_next   = SERVE;
                    end else if (serve_done) begin
                        state_next = PLAY;
                    end
                end
                PLAY: begin
                    if (is_pause) begin
                        state_next = PAUSED;
                        ret_next   = PLAY;
                    end else if (point_any) begin
                        do_inc = 1'b1;
                        if (new_score == SCORE_WIDTH'(WIN_SCORE)) begin
                            state_next = GAME_OVER;
                            latch_win  = 1'b1;
                        end else begin
                            state_next = SERVE;
                        end
                    end
                end
                PAUSED: begin
                    if (is_pause || is_start) begin
                        state_next = ret_state;
                    end else if (timeout_done) begin
                        state_next = IDLE;
                        do_clear   = 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (is_start) begin
                        state_next = SERVE;
                        do_clear   = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers. Status flags are computed from state_next so every output
    // comes straight from a flop and lines up with o_State.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            ret_state    <= IDLE;
            winner_id    <= '0;
            game_active  <= 1'b0;
            ball_release <= 1'b0;
            winner_valid <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                scores[p] <= '0;
            end
        end else begin
            state        <= state_next;
            ret_state    <= ret_next;
            game_active  <= (state_next == PLAY);
            // Only a completed serve releases the ball; resuming from
            // PAUSED into PLAY does not.
            ball_release <= (state == SERVE) && (state_next == PLAY);
            winner_valid <= (state_next == GAME_OVER);
            if (do_clear) begin
                winner_id <= '0;
            end else if (latch_win) begin
                winner_id <= point_idx;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (do_clear) begin
                    scores[p] <= '0;
                end else if (do_inc && (point_idx == IDW'(p))) begin
                    scores[p] <= new_score;
                end
            end
        end
    end

    assign o_State        = state;
    assign o_Game_Active  = game_active;
    assign o_Ball_Release = ball_release;
    assign o_Winner_Valid = winner_valid;
    assign o_Winner_Id    = winner_id;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_scores
        assign o_Scores[p*SCORE_WIDTH +: SCORE_WIDTH] = scores[p];
    end
endmodule
